// File: rtl/imem_line_buffer.sv
// rtl/imem_line_buffer.sv - instruction memory with a one-line fetch buffer,
// programmable miss latency, fault output and a word-wide program port
module imem_line_buffer #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               READ,
  input  logic [ADDR_WIDTH-1:0]              ADDRESS,
  output logic [31:0]                        READINST,
  output logic                               BUSYWAIT,
  output logic                               FAULT,
  input  logic                               PROG_WE,
  input  logic [$clog2(DEPTH_BYTES/4)-1:0]   PROG_ADDR,
  input  logic [31:0]                        PROG_DATA
);

  localparam int NWORDS = DEPTH_BYTES / 4;
  localparam int PW     = $clog2(NWORDS);
  localparam int OFF    = $clog2(LINE_WORDS) + 2;
  localparam int TW     = ADDR_WIDTH - OFF;
  localparam int CW     = $clog2(LATENCY + 1);
  localparam int WI_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, FILL} state_t;

  // Word-organised storage: word k's bits [7:0] are byte 4k, i.e. little-endian.
  logic [31:0]   mem    [NWORDS];
  logic [31:0]   line_q [LINE_WORDS];
  logic [TW-1:0] tag_q;
  logic          valid_q;
  logic [PW-1:0] fill_word_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q, state_d;

  logic            hit, bad, accept, miss_start, fill_done, prog_inval;
  logic [WI_W-1:0] word_sel;
  logic [PW-1:0]   fill_base;

  assign word_sel   = WI_W'((ADDRESS >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));
  assign hit        = valid_q && (ADDRESS[ADDR_WIDTH-1:OFF] == tag_q);
  assign bad        = (ADDRESS[1:0] != 2'b00) || (ADDRESS >= ADDR_WIDTH'(DEPTH_BYTES));
  assign accept     = (state_q == IDLE) && READ && (hit || bad);
  assign miss_start = (state_q == IDLE) && READ && !hit && !bad;
  assign fill_done  = (state_q == FILL) && (cnt_q == '0);
  assign fill_base  = fill_word_q & ~PW'(LINE_WORDS - 1);

  // A write into the buffered line or the line in flight must not leave stale data valid.
  assign prog_inval = PROG_WE &&
      ((TW'(ADDR_WIDTH'(PROG_ADDR) >> (OFF - 2)) == tag_q) ||
       ((state_q == FILL) &&
        (TW'(ADDR_WIDTH'(PROG_ADDR) >> (OFF - 2)) == TW'(ADDR_WIDTH'(fill_word_q) >> (OFF - 2)))));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    BUSYWAIT = 1'b0;
    case (state_q)
      IDLE: if (miss_start) begin
        BUSYWAIT = 1'b1;
        state_d  = FILL;
      end
      FILL: begin
        BUSYWAIT = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      READINST    <= '0;
      FAULT       <= 1'b0;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      fill_word_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (miss_start) begin
        fill_word_q <= PW'(ADDRESS >> 2);
        cnt_q       <= CW'(LATENCY - 1);
      end else if ((state_q == FILL) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (accept) begin
        READINST <= bad ? NOP : line_q[word_sel];
        FAULT    <= bad;
      end
      if (fill_done) begin
        READINST <= mem[fill_word_q];
        FAULT    <= 1'b0;
        tag_q    <= TW'(ADDR_WIDTH'(fill_word_q) >> (OFF - 2));
        valid_q  <= 1'b1;
      end
      if (prog_inval) valid_q <= 1'b0;
    end
  end

  // Array and line data carry no reset; valid_q alone qualifies the line.
  always_ff @(posedge CLK) begin
    if (PROG_WE) mem[PROG_ADDR] <= PROG_DATA;
    if (fill_done) begin
      for (int j = 0; j < LINE_WORDS; j++) line_q[j] <= mem[fill_base + PW'(j)];
    end
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// tb/tb_imem_line_buffer.sv - directed self-checking bench for imem_line_buffer
module tb_imem_line_buffer;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic [31:0] ADDRESS;
  logic [31:0] READINST;
  logic        BUSYWAIT;
  logic        FAULT;
  logic        PROG_WE;
  logic [7:0]  PROG_ADDR;
  logic [31:0] PROG_DATA;

  int n_checks = 0;
  int n_errors = 0;

  imem_line_buffer #(
    .DEPTH_BYTES(1024), .LINE_WORDS(4), .LATENCY(4), .ADDR_WIDTH(32)
  ) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
    .READINST(READINST), .BUSYWAIT(BUSYWAIT), .FAULT(FAULT),
    .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [7:0] widx, input logic [31:0] data);
    PROG_WE   = 1'b1;
    PROG_ADDR = widx;
    PROG_DATA = data;
    @(posedge CLK); #1;
    PROG_WE   = 1'b0;
  endtask

  // Counts BUSYWAIT-high cycles until acceptance, then samples after the accepting edge.
  task automatic fetch(input string tag, input logic [31:0] a, input int exp_stalls,
                       input logic [31:0] exp_data, input logic exp_fault);
    int stalls;
    READ    = 1'b1;
    ADDRESS = a;
    stalls  = 0;
    @(negedge CLK);
    while (BUSYWAIT && stalls < 20) begin
      stalls++;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    check({tag, "_stalls"}, stalls, exp_stalls);
    check({tag, "_data"}, READINST, exp_data);
    check({tag, "_fault"}, {31'd0, FAULT}, {31'd0, exp_fault});
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; ADDRESS = '0;
    PROG_WE = 1'b0; PROG_ADDR = '0; PROG_DATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_readinst", READINST, 32'h0);
    check("rst_fault", {31'd0, FAULT}, 32'h0);
    check("rst_busy", {31'd0, BUSYWAIT}, 32'h0);

    prog(8'd0, 32'h0190_0213);
    prog(8'd1, 32'h0230_0293);
    prog(8'd2, 32'h0052_0333);
    prog(8'd3, 32'h05A0_0093);
    for (int i = 4; i < 12; i++) prog(8'(i), 32'h1000_0000 + i);

    READ = 1'b1; ADDRESS = 32'd0;
    RESET = 1'b1;
    #1 check("rel_busy", {31'd0, BUSYWAIT}, 32'h1);

    fetch("cold0", 32'd0, 5, 32'h0190_0213, 1'b0);
    fetch("hit4", 32'd4, 0, 32'h0230_0293, 1'b0);
    fetch("hit8", 32'd8, 0, 32'h0052_0333, 1'b0);
    fetch("hit12", 32'd12, 0, 32'h05A0_0093, 1'b0);
    fetch("line16", 32'd16, 5, 32'h1000_0004, 1'b0);
    fetch("back0", 32'd0, 5, 32'h0190_0213, 1'b0);

    fetch("mis2", 32'd2, 0, 32'h0000_0013, 1'b1);
    fetch("oor1024", 32'd1024, 0, 32'h0000_0013, 1'b1);
    fetch("clr4", 32'd4, 0, 32'h0230_0293, 1'b0);

    READ = 1'b0; ADDRESS = 32'd8;
    repeat (2) @(posedge CLK); #1;
    check("hold_data", READINST, 32'h0230_0293);
    check("hold_busy", {31'd0, BUSYWAIT}, 32'h0);

    prog(8'd1, 32'h4042_8333);
    fetch("coh4", 32'd4, 5, 32'h4042_8333, 1'b0);

    READ = 1'b1; ADDRESS = 32'd32;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("midfill_data", READINST, 32'h0);
    check("midfill_fault", {31'd0, FAULT}, 32'h0);
    READ = 1'b0;
    #1 check("midfill_idle", {31'd0, BUSYWAIT}, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    fetch("refill32", 32'd32, 5, 32'h1000_0008, 1'b0);
    fetch("hit36", 32'd36, 0, 32'h1000_0009, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
